// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable sequence detector.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    DISABLED,
    FILL,
    HUNT
  } seq_state_e;

  // Width needed to hold a pattern length in the range 0..max_len.
  function automatic int seq_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Masked compare: only the low `len` bits of the shifted history and the
// pattern take part in the match.
module seq_match_cmp
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8
) (
  input  logic [MAX_LEN-1:0]            hist_next,
  input  logic [MAX_LEN-1:0]            pattern,
  input  logic [seq_len_w(MAX_LEN)-1:0] len,
  output logic                          equal
);

  logic [MAX_LEN-1:0] mask;

  // Build the length mask and compare under it.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    equal = (((hist_next ^ pattern) & mask) == '0);
  end

endmodule

// File: rtl/detect_programmable_sequence_using_fsm.sv
// Runtime-programmable serial pattern detector with overlap control,
// valid-qualified input and a saturating match counter.
module detect_programmable_sequence_using_fsm
  import seq_detect_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter int                 RST_LEN     = 6,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0011_0011
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          a_valid,
  input  logic                          a,
  input  logic                          overlap,
  input  logic                          cfg_valid,
  input  logic [seq_len_w(MAX_LEN)-1:0] cfg_len,
  input  logic [MAX_LEN-1:0]            cfg_pattern,
  output logic                          cfg_ready,
  output logic                          cfg_error,
  input  logic                          cnt_clr,
  output logic                          detected,
  output logic [CNT_W-1:0]              match_count
);

  localparam int LEN_W = seq_len_w(MAX_LEN);

  seq_state_e         state, state_nxt;
  logic [MAX_LEN-1:0] hist, hist_nxt, hist_shift, pattern;
  logic [LEN_W-1:0]   fill, fill_nxt, fill_inc, len;
  logic               pat_eq, match;
  logic               cfg_take, cfg_bad;

  assign hist_shift = {hist[MAX_LEN-2:0], a};
  assign fill_inc   = fill + LEN_W'(1);
  assign cfg_ready  = (state == DISABLED);
  assign cfg_take   = cfg_valid && cfg_ready;
  assign cfg_bad    = (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));

  seq_match_cmp #(
    .MAX_LEN(MAX_LEN)
  ) u_cmp (
    .hist_next(hist_shift),
    .pattern  (pattern),
    .len      (len),
    .equal    (pat_eq)
  );

  // Next-state, history/fill update and match decision.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_nxt = state;
    hist_nxt  = hist;
    fill_nxt  = fill;
    match     = 1'b0;
    if (!enable) begin
      // A bit accepted in this cycle is dropped along with the history.
      state_nxt = DISABLED;
      hist_nxt  = '0;
      fill_nxt  = '0;
    end else begin
      case (state)
        DISABLED: begin
          state_nxt = FILL;
          hist_nxt  = '0;
          fill_nxt  = '0;
        end
        FILL: begin
          if (a_valid) begin
            hist_nxt = hist_shift;
            if (fill_inc == len) begin
              match = pat_eq;
              if (pat_eq && !overlap) begin
                fill_nxt  = '0;
                state_nxt = FILL;
              end else begin
                fill_nxt  = len;
                state_nxt = HUNT;
              end
            end else begin
              fill_nxt = fill_inc;
            end
          end
        end
        HUNT: begin
          if (a_valid) begin
            hist_nxt = hist_shift;
            match    = pat_eq;
            if (pat_eq && !overlap) begin
              fill_nxt  = '0;
              state_nxt = FILL;
            end
          end
        end
        default: state_nxt = DISABLED;
      endcase
    end
  end

  // State register, history, fill and registered match pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // see the same pre-edge values regardless of statement order.
    if (rst) begin
      state    <= DISABLED;
      hist     <= '0;
      fill     <= '0;
      detected <= 1'b0;
    end else begin
      state    <= state_nxt;
      hist     <= hist_nxt;
      fill     <= fill_nxt;
      detected <= match;
    end
  end

  // Configuration load and rejection pulse; only legal while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      len       <= LEN_W'(RST_LEN);
      pattern   <= RST_PATTERN;
      cfg_error <= 1'b0;
    end else begin
      cfg_error <= cfg_take && cfg_bad;
      if (cfg_take && !cfg_bad) begin
        len     <= cfg_len;
        pattern <= cfg_pattern;
      end
    end
  end

  // Saturating match counter; a clear coinciding with a match leaves 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_count <= '0;
    end else if (cfg_take && !cfg_bad) begin
      match_count <= '0;
    end else if (cnt_clr) begin
      match_count <= match ? CNT_W'(1) : '0;
    end else if (match && (match_count != '1)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_detect_programmable_sequence_using_fsm.sv
// Directed bench for the programmable sequence detector. A second instance
// with a 2-bit counter shares the stimulus for the saturation checks.
module tb_detect_programmable_sequence_using_fsm;

  logic       clk = 1'b0;
  logic       rst, enable, a_valid, a, overlap, cfg_valid, cnt_clr;
  logic [3:0] cfg_len;
  logic [7:0] cfg_pattern;

  logic        cfg_ready, cfg_error, detected;
  logic [15:0] match_count;
  logic        cfg_ready2, cfg_error2, detected2;
  logic [1:0]  match_count2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  detect_programmable_sequence_using_fsm dut (
    .clk(clk), .rst(rst), .enable(enable), .a_valid(a_valid), .a(a),
    .overlap(overlap), .cfg_valid(cfg_valid), .cfg_len(cfg_len),
    .cfg_pattern(cfg_pattern), .cfg_ready(cfg_ready), .cfg_error(cfg_error),
    .cnt_clr(cnt_clr), .detected(detected), .match_count(match_count)
  );

  detect_programmable_sequence_using_fsm #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .a_valid(a_valid), .a(a),
    .overlap(overlap), .cfg_valid(cfg_valid), .cfg_len(cfg_len),
    .cfg_pattern(cfg_pattern), .cfg_ready(cfg_ready2), .cfg_error(cfg_error2),
    .cnt_clr(cnt_clr), .detected(detected2), .match_count(match_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted bit, then check the registered pulse it produces.
  task automatic send(input logic b, input logic exp_det, input string tag);
    a_valid = 1'b1;
    a       = b;
    tick();
    a_valid = 1'b0;
    a       = 1'b0;
    check(tag, detected, exp_det);
  endtask

  task automatic configure(input logic [3:0] l, input logic [7:0] p);
    cfg_valid   = 1'b1;
    cfg_len     = l;
    cfg_pattern = p;
    tick();
    cfg_valid   = 1'b0;
  endtask

  task automatic restart();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; a_valid = 1'b0; a = 1'b0; overlap = 1'b1;
    cfg_valid = 1'b0; cfg_len = '0; cfg_pattern = '0; cnt_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    check("rst_detected", detected, 0);
    check("rst_count", match_count, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_cfg_error", cfg_error, 0);

    // Default pattern 110011.
    enable = 1'b1;
    tick();
    check("en_cfg_ready", cfg_ready, 0);
    send(1, 0, "def_b1"); send(1, 0, "def_b2"); send(0, 0, "def_b3");
    send(0, 0, "def_b4"); send(1, 0, "def_b5"); send(1, 1, "def_b6");
    check("def_count", match_count, 1);
    tick();
    check("def_pulse_end", detected, 0);

    // Overlap on 1010 with stream 101010.
    enable = 1'b0;
    tick();
    configure(4'd4, 8'b0000_1010);
    check("cfg_clears_count", match_count, 0);
    enable = 1'b1;
    tick();
    send(1, 0, "ov_b1"); send(0, 0, "ov_b2"); send(1, 0, "ov_b3");
    send(0, 1, "ov_b4"); send(1, 0, "ov_b5"); send(0, 1, "ov_b6");
    check("ov_count", match_count, 2);

    // Non-overlap on the same stream: one more match only.
    overlap = 1'b0;
    restart();
    send(1, 0, "nov_b1"); send(0, 0, "nov_b2"); send(1, 0, "nov_b3");
    send(0, 1, "nov_b4"); send(1, 0, "nov_b5"); send(0, 0, "nov_b6");
    check("nov_count", match_count, 3);

    // Valid gaps inside 110011.
    enable = 1'b0;
    tick();
    configure(4'd6, 8'b0011_0011);
    enable = 1'b1;
    tick();
    send(1, 0, "gap_b1"); send(1, 0, "gap_b2"); send(0, 0, "gap_b3");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gap_idle", detected, 0);
    end
    send(0, 0, "gap_b4"); send(1, 0, "gap_b5"); send(1, 1, "gap_b6");
    check("gap_count", match_count, 1);

    // Rejected configurations leave pattern and count alone.
    enable = 1'b0;
    tick();
    configure(4'd0, 8'hFF);
    check("bad_len0_err", cfg_error, 1);
    tick();
    check("bad_err_pulse_end", cfg_error, 0);
    configure(4'd9, 8'hFF);
    check("bad_len9_err", cfg_error, 1);
    check("bad_keeps_count", match_count, 1);
    enable = 1'b1;
    tick();
    // Config while enabled is ignored without an error.
    configure(4'd4, 8'b0000_1010);
    check("busy_cfg_no_err", cfg_error, 0);
    send(1, 0, "old_b1"); send(1, 0, "old_b2"); send(0, 0, "old_b3");
    send(0, 0, "old_b4"); send(1, 0, "old_b5"); send(1, 1, "old_b6");
    check("old_count", match_count, 2);

    // Disable mid-match discards progress.
    restart();
    send(1, 0, "dis_b1"); send(1, 0, "dis_b2"); send(0, 0, "dis_b3");
    send(0, 0, "dis_b4"); send(1, 0, "dis_b5");
    restart();
    send(1, 0, "dis_last");
    send(1, 0, "re_b1"); send(1, 0, "re_b2"); send(0, 0, "re_b3");
    send(0, 0, "re_b4"); send(1, 0, "re_b5"); send(1, 1, "re_b6");
    tick();
    check("re_pulse_end", detected, 0);

    // Saturation on the 2-bit counter, len=1 pattern 1, non-overlap.
    enable = 1'b0;
    tick();
    configure(4'd1, 8'b0000_0001);
    check("sat_cleared", match_count2, 0);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      a_valid = 1'b1;
      a       = 1'b1;
      tick();
      check("sat_det", detected2, 1);
      check("sat_count", match_count2, (i < 3) ? i + 1 : 3);
    end
    a = 1'b0;
    tick();
    check("sat_zero_no_det", detected2, 0);
    check("sat_zero_hold", match_count2, 3);
    a       = 1'b1;
    cnt_clr = 1'b1;
    tick();
    check("clr_with_match", match_count2, 1);
    a_valid = 1'b0;
    tick();
    check("clr_alone", match_count2, 0);
    cnt_clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
